// File: rtl/mac_pkg.sv
// Shared constants for the mac column sequencer: instruction codes and FSM state encoding.
package mac_pkg;

    localparam logic [1:0] INST_NOP   = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_ISSUE = 2'd1;
    localparam seq_state_t ST_TAIL  = 2'd2;
    localparam seq_state_t ST_GAP   = 2'd3;

    function automatic logic op_is_valid(input logic [1:0] op);
        return (op == INST_KLOAD) || (op == INST_EXEC);
    endfunction

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter with a terminal flag (count == 1); used for vector and drain counts.
module mac_seq_cnt
    import mac_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == W'(1));

endmodule

// File: rtl/mac_seq.sv
// Command sequencer feeding the first mac_col: streams len vectors from Q/K memory, drains, pulses done.
// Optional `stall` input on ISSUE is enabled by defining MAC_SEQ_STALL_EN.
module mac_seq
    import mac_pkg::*;
#(
    parameter int unsigned bw      = 8,
    parameter int unsigned pr      = 8,
    parameter int unsigned addr_bw = 8,
    parameter int unsigned len_bw  = 8,
    parameter int unsigned gap     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [addr_bw-1:0] cmd_base,
    input  logic [len_bw-1:0]  cmd_len,
    output logic               mem_rd,
    output logic [addr_bw-1:0] mem_addr,
    input  logic [bw*pr-1:0]   mem_rdata,
    output logic [bw*pr-1:0]   q_out,
    output logic [1:0]         o_inst,
    output logic               busy,
    output logic               done
`ifdef MAC_SEQ_STALL_EN
    ,
    input  logic               stall
`endif
);

    seq_state_t         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [addr_bw-1:0] mem_addr_q, mem_addr_d;
    logic               mem_rd_q, mem_rd_d;
    logic [1:0]         o_inst_q, o_inst_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cmd_ready_q, cmd_ready_d;

    logic               len_load, len_dec, len_term;
    logic               gap_load, gap_dec, gap_term;
    logic [15:0]        gap_val;
    logic               stall_i;

`ifdef MAC_SEQ_STALL_EN
    assign stall_i = stall;
`else
    assign stall_i = 1'b0;
`endif

    mac_seq_cnt #(.W(len_bw)) u_len_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (len_load),
        .load_val (cmd_len),
        .dec      (len_dec),
        .term     (len_term)
    );

    mac_seq_cnt #(.W(16)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (gap_val),
        .dec      (gap_dec),
        .term     (gap_term)
    );

    // Outputs are registered, so each branch computes what the next cycle shows.
    // In ISSUE, mem_rd_q marks that the current cycle consumed a vector; a stall only inserts bubbles.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        o_inst_d   = INST_NOP;
        done_d     = 1'b0;
        len_load   = 1'b0;
        len_dec    = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        gap_val    = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d       = cmd_op;
                    mem_addr_d = cmd_base;
                    if ((cmd_len != '0) && op_is_valid(cmd_op)) begin
                        state_d  = ST_ISSUE;
                        len_load = 1'b1;
                        mem_rd_d = 1'b1;
                        o_inst_d = cmd_op;
                    end else begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                        gap_val  = 16'd1;
                    end
                end
            end
            ST_ISSUE: begin
                len_dec = mem_rd_q;
                if (mem_rd_q && len_term) begin
                    state_d = ST_TAIL;
                end else begin
                    mem_addr_d = mem_addr_q + addr_bw'(mem_rd_q);
                    if (!stall_i) begin
                        mem_rd_d = 1'b1;
                        o_inst_d = op_q;
                    end
                end
            end
            ST_TAIL: begin
                gap_load = 1'b1;
                gap_val  = 16'(gap);
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (gap_term) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
        valid_d     = mem_rd_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= INST_NOP;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            o_inst_q    <= INST_NOP;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            o_inst_q    <= o_inst_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign o_inst    = o_inst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign q_out     = valid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: directed table, reset abort, randomized commands vs. a cycle-timeline model.
// Exercises the stall input when MAC_SEQ_STALL_EN is defined.
module tb_mac_seq;
    import mac_pkg::*;

    localparam int unsigned BW  = 8;
    localparam int unsigned PR  = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned LW  = 8;
    localparam int unsigned GAP = 3;
    localparam int unsigned VW  = BW * PR;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [VW-1:0] mem_rdata = {VW{1'b1}};
    logic [VW-1:0] q_out;
    logic [1:0]    o_inst;
    logic          busy;
    logic          done;
`ifdef MAC_SEQ_STALL_EN
    logic          stall;
`endif

    logic [VW-1:0] mem [0:255];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory; rdata keeps its last value when not read.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    mac_seq #(
        .bw(BW), .pr(PR), .addr_bw(AW), .len_bw(LW), .gap(GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .q_out     (q_out),
        .o_inst    (o_inst),
        .busy      (busy),
        .done      (done)
`ifdef MAC_SEQ_STALL_EN
        ,
        .stall     (stall)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, " mem_rd"},    64'(mem_rd),    64'd0);
        check({tag, " mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, " q_out"},     64'(q_out),     64'd0);
        check({tag, " o_inst"},    64'(o_inst),    64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
        check({tag, " done"},      64'(done),      64'd0);
    endtask

    // Drives one command (called at a negedge) and returns after the accept edge; ok=0 on timeout.
    task automatic issue_cmd(input logic [1:0] op, input logic [7:0] base, input logic [7:0] len,
                             input string tag, output bit ok);
        int unsigned w = 0;
        ok = 1'b0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check({tag, " cmd_ready wait"}, 64'(cmd_ready), 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Runs one command and checks every cycle from E0+1 to done against the timeline the command implies.
    // stall_at != 0 stalls cycles E0+stall_at and E0+stall_at+1 and checks order/counts instead.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] base, input logic [7:0] len,
                           input int unsigned stall_at, input int unsigned exp_lat, input string tag);
        bit            ok;
        bit            good_cmd;
        int unsigned   tot;
        int unsigned   lat;
        int unsigned   n_inst;
        logic [7:0]    addrs[$];
        logic [VW-1:0] qs[$];
        logic [7:0]    a;

        good_cmd = (len != 0) && (op == INST_KLOAD || op == INST_EXEC);
        tot      = good_cmd ? (int'(len) + 2 + GAP) : 2;
        lat      = 0;
        n_inst   = 0;

        issue_cmd(op, base, len, tag, ok);
        if (!ok) return;

        for (int unsigned c = 1; c <= tot + 8; c++) begin
`ifdef MAC_SEQ_STALL_EN
            stall = (stall_at != 0) && (c == stall_at || c == stall_at + 1);
`endif
            @(negedge clk);
            if (stall_at == 0 && c <= tot) begin
                bit            act;
                logic [1:0]    e_inst;
                logic [VW-1:0] e_q;
                string         p;
                p      = $sformatf("%s c%0d", tag, c);
                act    = good_cmd && c <= len;
                e_inst = act ? op : INST_NOP;
                a      = base + 8'(c - 1);
                check({p, " o_inst"}, 64'(o_inst), 64'(e_inst));
                check({p, " mem_rd"}, 64'(mem_rd), 64'(act));
                if (act) check({p, " mem_addr"}, 64'(mem_addr), 64'(a));
                a   = base + 8'(c - 2);
                e_q = (good_cmd && c >= 2 && c <= int'(len) + 1) ? mem[a] : '0;
                check({p, " q_out"},     64'(q_out),     64'(e_q));
                check({p, " busy"},      64'(busy),      64'(c < tot));
                check({p, " cmd_ready"}, 64'(cmd_ready), 64'(c == tot));
                check({p, " done"},      64'(done),      64'(c == tot));
            end
            if (o_inst != INST_NOP) n_inst++;
            if (mem_rd) addrs.push_back(mem_addr);
            if (q_out != '0) qs.push_back(q_out);
            if (done) begin
                lat = c;
                break;
            end
        end
`ifdef MAC_SEQ_STALL_EN
        stall = 1'b0;
`endif
        if (lat == 0) begin
            check({tag, " done timeout"}, 64'(done), 64'd1);
            return;
        end
        check({tag, " done latency"}, 64'(lat), 64'(exp_lat));
        if (stall_at != 0) begin
            check({tag, " inst count"}, 64'(n_inst), 64'(len));
            check({tag, " rd count"}, 64'(addrs.size()), 64'(len));
            check({tag, " q count"}, 64'(qs.size()), 64'(len));
            for (int unsigned k = 0; k < len; k++) begin
                a = base + 8'(k);
                if (k < addrs.size()) check($sformatf("%s addr%0d", tag, k), 64'(addrs[k]), 64'(a));
                if (k < qs.size())    check($sformatf("%s q%0d", tag, k), 64'(qs[k]), 64'(mem[a]));
            end
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  base;
        logic [7:0]  len;
        int unsigned lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom} | 64'h1;
        for (int e = 0; e < 8; e++) begin
            mem[0][8*e +: 8] = 8'(e + 1);
            mem[1][8*e +: 8] = 8'(2*e + 1);
            mem[2][8*e +: 8] = 8'(2*e + 2);
        end

        // Done latency per row is len+2+gap for real work, 2 for empty/invalid commands.
        tbl[0] = '{INST_KLOAD, 8'd0,   8'd3,   8};
        tbl[1] = '{INST_EXEC,  8'd254, 8'd3,   8};
        tbl[2] = '{INST_EXEC,  8'd255, 8'd3,   8};
        tbl[3] = '{INST_EXEC,  8'd5,   8'd0,   2};
        tbl[4] = '{2'b11,      8'd7,   8'd4,   2};
        tbl[5] = '{INST_NOP,   8'd7,   8'd4,   2};
        tbl[6] = '{INST_KLOAD, 8'd100, 8'd1,   6};
        tbl[7] = '{INST_EXEC,  8'd0,   8'd255, 260};

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_base  = '0;
        cmd_len   = '0;
`ifdef MAC_SEQ_STALL_EN
        stall     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].op, tbl[i].base, tbl[i].len, 0, tbl[i].lat, $sformatf("tbl%0d", i));
        end

        // Abort mid-ISSUE at k=1, then a fresh command must run cleanly.
        issue_cmd(INST_EXEC, 8'd10, 8'd5, "abort", ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            check("abort k1 o_inst", 64'(o_inst), 64'(INST_EXEC));
            check("abort k1 mem_addr", 64'(mem_addr), 64'd11);
            reset = 1'b0;
            @(negedge clk);
            check_reset_outputs("abort");
            reset = 1'b1;
            @(negedge clk);
        end
        run_cmd(INST_KLOAD, 8'd1, 8'd2, 0, 2 + 2 + GAP, "post_abort");

`ifdef MAC_SEQ_STALL_EN
        run_cmd(INST_EXEC, 8'd40, 8'd4, 2, 4 + 2 + GAP + 2, "stall");
`endif

        for (int r = 0; r < 24; r++) begin
            logic [1:0] op;
            logic [7:0] base;
            logic [7:0] len;
            bit         good;
            op   = 2'($urandom_range(0, 3));
            if (op == 2'b11 && $urandom_range(0, 1) == 1) op = INST_EXEC;
            base = 8'($urandom);
            len  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
            good = (len != 0) && (op == INST_KLOAD || op == INST_EXEC);
            run_cmd(op, base, len, 0, good ? (int'(len) + 2 + GAP) : 2, $sformatf("rnd%0d", r));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
# mac_seq

Command-driven sequencer that drives the instruction/data inputs of the first `mac_col` in a column chain. It accepts a load-K or execute command, streams `len` 64-bit vectors from a synchronous-read Q/K memory onto `q_out` with the matching `o_inst` code, and then waits a configurable drain interval so the column pipeline finishes. It then signals `done`. It sits between the top-level controller and `mac_col_instance_0`.

## Interface
- `bw`, 8 — element width in bits
- `pr`, 8 — elements per vector; the vector is `bw*pr` bits
- `addr_bw`, 8 — memory address width
- `len_bw`, 8 — width of the command length field
- `gap`, 16 — drain cycles after the last vector; minimum 1
- `clk`  in  1  — the single clock
- `reset`  in  1  — synchronous, active-low (0 = reset)
- `cmd_valid`  in  1  — command present
- `cmd_ready`  out  1  — sequencer can accept a command
- `cmd_op`  in  2  — 01 = load K, 10 = execute
- `cmd_base`  in  addr_bw  — first memory address
- `cmd_len`  in  len_bw  — number of vectors
- `mem_rd`  out  1  — memory read enable
- `mem_addr`  out  addr_bw  — memory read address
- `mem_rdata`  in  bw*pr  — memory data, valid the cycle after the `mem_rd` edge
- `q_out`  out  bw*pr  — vector to `mac_col.q_in`
- `o_inst`  out  2  — instruction to `mac_col.i_inst`
- `busy`  out  1  — high while not IDLE
- `done`  out  1  — one-cycle completion pulse

## Operation
- The FSM has four states: IDLE, ISSUE, TAIL, GAP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch op/base/len.
  - If len≠0 and op∈{01,10}, go to ISSUE. Otherwise go to GAP with the counter preloaded to 1, so nothing is issued and `done` still pulses.
- **ISSUE**, one cycle per vector k = 0..len-1:
  - `o_inst`=op, `mem_rd`=1, `mem_addr`=base+k.
  - After the cycle with k=len-1, go to TAIL.
- **TAIL**, one cycle: `o_inst`=00, `mem_rd`=0. The last vector is on `q_out`. Load the drain counter with `gap`, then go to GAP.
- **GAP**: decrement the counter. At 1, go to IDLE and pulse `done`.
- `q_out` = `mem_rdata` when the data-valid flag is set, else 0. The data-valid flag is registered and equals `mem_rd` delayed by one cycle.
- Address arithmetic is modulo 2^addr_bw: base=255, len=3 reads 255, 0, 1.
- Commands presented while `cmd_ready`=0 are not accepted. `cmd_valid` must hold until it is accepted.
- Reset asserted mid-command: the command is dropped. On the next edge all registers are cleared and the FSM is in IDLE.

## Timing
- Reset values: `cmd_ready`=1, `mem_rd`=0, `mem_addr`=0, `q_out`=0, `o_inst`=00, `busy`=0, `done`=0.
- Accept edge E0:
  - `o_inst`=op from cycle E0+1 through E0+len.
  - Vector k is on `q_out` in cycle E0+2+k, one cycle after its `o_inst` cycle. This matches the `mac_col` inst-then-data contract.
- TAIL is cycle E0+len+1. GAP spans E0+len+2 .. E0+len+1+gap.
- `done`=1 and `cmd_ready`=1 together in cycle E0+len+2+gap.
- A new command can be accepted in that same cycle.
- All outputs are registered except `q_out`, which is the registered valid flag AND-gated with `mem_rdata`.
- The length counter is `len_bw` bits; len=2^len_bw-1 is legal. The gap counter is 16 bits.

## Configuration
- `MAC_SEQ_STALL_EN`: when defined, an extra input `stall` (1 bit) exists.
  - `stall`=1 in ISSUE: `o_inst`=00, `mem_rd`=0, address and count hold.
  - The vector already in flight still appears on `q_out` the next cycle.
  - `stall` is ignored in other states.
- Undefined: no `stall` port; ISSUE never pauses.

## Structure
- Shared package `mac_pkg` holds:
  - instruction constants `INST_NOP`=2'b00, `INST_KLOAD`=2'b01, `INST_EXEC`=2'b10;
  - the FSM state encoding.
- Sub-module `mac_seq_cnt`: loadable down-counter with a terminal flag, reused for the length and gap counts.
- Expected size is about 180 lines of RTL.

## Test plan
- Reset held low 3 cycles → all outputs at reset values.
- Release reset, then load-K base=0 len=3, with memory holding {1..8}, {1,3,..15}, {2,4,..16} → `o_inst`=01 for 3 cycles; those vectors appear on `q_out` one cycle later each; `done` at E0+3+2+gap.
- Execute base=254 len=3 → `mem_addr` 254, 255, 0; `o_inst`=10 ×3; then `done`.
- len=0 and op=11 → no `o_inst`/`mem_rd` activity; `done` at E0+2.
- Reset pulled low during ISSUE at k=1 → next cycle all outputs 0; a fresh command runs normally.
- With `MAC_SEQ_STALL_EN`: `stall` high for 2 cycles during len=4 execute → 4 `o_inst` cycles across 6; `q_out` order intact; `done` 2 cycles later than the unstalled run.
